// File: rtl/uart_tx.sv
// UART transmitter: start bit, WordSize data bits LSB first, one stop bit, no parity.
// Words arrive over a valid/ack handshake; the serial line idles high.
module uart_tx #(
    parameter int unsigned ClkRate  = 100_000_000,
    parameter int unsigned BaudRate = 115200,
    parameter int unsigned WordSize = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [WordSize-1:0] data_i,
    input  logic                data_valid_i,
    output logic                data_ack_o,
    output logic                uart_o
);

    localparam int unsigned BitCycles = ClkRate / BaudRate;
    localparam int unsigned CntW      = (BitCycles > 1) ? $clog2(BitCycles) : 1;
    localparam int unsigned IdxW      = (WordSize > 1) ? $clog2(WordSize) : 1;

    localparam logic [CntW-1:0] CntLast = CntW'(BitCycles - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WordSize - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    generate
        if (BitCycles < 2) begin : g_bad_divider
            $error("uart_tx: ClkRate/BaudRate must be at least 2");
        end
    endgenerate

    logic [1:0]          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [WordSize-1:0] shift_q, shift_d;
    logic                uart_q, uart_d;
    logic                bit_end_c;

    assign bit_end_c = (cnt_q == CntLast);

    // Ack only while idle; forced low for the whole time reset is asserted.
    assign data_ack_o = (state_q == StIdle) && data_valid_i && !rst_i;
    assign uart_o     = uart_q;

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            uart_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            uart_q  <= uart_d;
        end
    end

    // Next state; uart_d is the line level for the cycle after this edge,
    // so the start bit appears on the same edge that accepts the word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        uart_d  = uart_q;

        case (state_q)
            StIdle: begin
                uart_d = 1'b1;
                if (data_valid_i) begin
                    shift_d = data_i;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StStart;
                    uart_d  = 1'b0;
                end
            end
            StStart: begin
                if (bit_end_c) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StData;
                    uart_d  = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_end_c) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IdxLast) begin
                        state_d = StStop;
                        uart_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + IdxW'(1);
                        uart_d = shift_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (bit_end_c) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    uart_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                uart_d  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: cycle-level line/ack model, mid-bit decoder, directed and random words.
module tb_uart_tx;

    localparam int unsigned ClkRate  = 100_000_000;
    localparam int unsigned BaudRate = 115200;
    localparam int unsigned WordSize = 8;
    localparam int unsigned BC       = ClkRate / BaudRate;
    localparam int unsigned FrameLen = (WordSize + 2) * BC;

    logic                clk = 1'b0;
    logic                rst;
    logic [WordSize-1:0] data;
    logic                valid;
    logic                ack;
    logic                uart;

    uart_tx #(
        .ClkRate (ClkRate),
        .BaudRate(BaudRate),
        .WordSize(WordSize)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (data),
        .data_valid_i(valid),
        .data_ack_o  (ack),
        .uart_o      (uart)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned ack_cnt  = 0;

    bit                  exp_line[$];
    logic [WordSize-1:0] exp_words[$];
    logic [WordSize-1:0] rx_q[$];
    bit                  pend = 1'b0;
    logic [WordSize-1:0] pend_word;
    bit                  busy;
    bit                  e_line;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: an accepted word becomes (WordSize+2)*BC expected line samples.
    always @(negedge clk) begin
        if (rst) begin
            if (exp_line.size() != 0 && exp_words.size() != 0) void'(exp_words.pop_back());
            exp_line.delete();
            pend = 1'b0;
            check("reset_line", uart, 1);
            check("reset_ack", ack, 0);
        end else begin
            if (pend) begin
                for (int b = 0; b < int'(WordSize) + 2; b++) begin
                    bit v;
                    v = (b == 0) ? 1'b0 : (b == int'(WordSize) + 1) ? 1'b1 : pend_word[b-1];
                    repeat (BC) exp_line.push_back(v);
                end
                exp_words.push_back(pend_word);
                pend = 1'b0;
            end
            busy   = (exp_line.size() != 0);
            e_line = busy ? exp_line.pop_front() : 1'b1;
            check("line", uart, e_line);
            check("ack", ack, valid && !busy);
            check("ack_without_valid", ack && !valid, 0);
            if (!valid && !busy) check("idle_high", uart, 1);
            check("line_known", $isunknown(uart), 0);
            if (ack) ack_cnt++;
            if (valid && !busy) begin
                pend      = 1'b1;
                pend_word = data;
            end
        end
    end

    // Mid-bit decoder; a reset during a frame abandons it.
    task automatic dwait(input int unsigned n, inout bit ab);
        for (int unsigned i = 0; i < n; i++) begin
            if (ab) return;
            @(posedge clk);
            #1;
            if (rst) ab = 1'b1;
        end
    endtask

    task automatic decode_frame();
        bit                  ab = 1'b0;
        logic [WordSize-1:0] w = '0;
        dwait(BC / 2, ab);
        if (!ab) check("dec_start", uart, 0);
        for (int i = 0; i < int'(WordSize); i++) begin
            dwait(BC, ab);
            if (!ab) w[i] = uart;
        end
        dwait(BC, ab);
        if (!ab) begin
            check("dec_stop", uart, 1);
            rx_q.push_back(w);
        end
    endtask

    initial begin
        forever begin
            @(negedge uart);
            if (!rst) decode_frame();
        end
    end

    task automatic idle_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int unsigned at_cyc);
        at_cyc = 0;
        for (int unsigned i = 0; i < FrameLen + 100; i++) begin
            @(negedge clk);
            if (ack) begin
                at_cyc = cyc;
                @(posedge clk);
                #1;
                return;
            end
        end
        check("ack_timeout", 0, 1);
    endtask

    task automatic send(input logic [WordSize-1:0] w, output int unsigned at_cyc);
        data  = w;
        valid = 1'b1;
        wait_ack(at_cyc);
    endtask

    task automatic wait_line_idle();
        for (int unsigned i = 0; i < FrameLen + 100; i++) begin
            @(posedge clk);
            #1;
            if (exp_line.size() == 0) begin
                idle_cycles(2);
                return;
            end
        end
        check("idle_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int unsigned t_ab, t_bc, t_x, a0, gap;
        logic [WordSize-1:0] w;
        rst   = 1'b0;
        valid = 1'b0;
        data  = '0;
        #1 rst = 1'b1;
        repeat (100) @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(5);
        check("post_reset_line", uart, 1);

        // 0xAB, then 0xBC presented immediately with valid held high.
        a0 = ack_cnt;
        send(8'hAB, t_ab);
        data = 8'hBC;
        send(8'hBC, t_bc);
        check("b2b_ack_spacing", t_bc - t_ab, FrameLen + 1);
        check("ack_pulses_two_words", ack_cnt - a0, 2);
        valid = 1'b0;
        data  = 8'h00;
        wait_line_idle();

        // Ten bit-period gap, then 0xCD.
        idle_cycles(10 * BC);
        send(8'hCD, t_x);
        valid = 1'b0;
        wait_line_idle();
        check("rx_count_3", rx_q.size(), 3);
        if (rx_q.size() >= 3) begin
            check("rx0_AB", rx_q[0], 8'hAB);
            check("rx1_BC", rx_q[1], 8'hBC);
            check("rx2_CD", rx_q[2], 8'hCD);
        end

        // Reset in the middle of data bit 1 (a 0) of 0x55.
        send(8'h55, t_x);
        valid = 1'b0;
        idle_cycles(2 * BC + BC / 2);
        check("mid_frame_line_low", uart, 0);
        #2 rst = 1'b1;
        #1;
        check("reset_immediate_line", uart, 1);
        check("reset_immediate_ack", ack, 0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(3);
        check("aborted_not_received", rx_q.size(), 3);
        send(8'h3C, t_x);
        valid = 1'b0;
        wait_line_idle();
        check("rx_count_4", rx_q.size(), 4);
        if (rx_q.size() >= 4) check("rx3_3C", rx_q[3], 8'h3C);

        // Random words; data and valid wander while the transmitter is busy.
        for (int k = 0; k < 3; k++) begin
            w = WordSize'($urandom);
            send(w, t_x);
            data  = WordSize'($urandom);
            valid = 1'($urandom_range(0, 1));
            gap   = $urandom_range(1, 200);
            idle_cycles(gap);
        end
        valid = 1'b0;
        wait_line_idle();
        idle_cycles(BC);

        check("rx_vs_model_count", rx_q.size(), exp_words.size());
        for (int i = 0; i < rx_q.size() && i < exp_words.size(); i++)
            check("rx_vs_model_word", rx_q[i], exp_words[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Parameterised UART transmitter: 8N1-style framing (start bit, WordSize data bits LSB first, one stop bit, no parity).
- Accepts words over a valid/acknowledge handshake from an upstream producer, e.g. a byte source or FIFO.
- Drives a single serial line that idles high.
- Baud timing derives from an integer clock divider.

Parameters:
- ClkRate, 100_000_000, input clock frequency in Hz.
- BaudRate, 115200, serial bit rate in bits/s.
- WordSize, 8, data bits per frame.

Ports:
- clk_i  input  1  system clock; all state updates on its rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- data_i  input  WordSize  word to transmit; sampled only on the accepting edge.
- data_valid_i  input  1  producer has a word on data_i; held high until acknowledged.
- data_ack_o  output  1  word accepted this cycle; transfer occurs on the rising edge where data_valid_i && data_ack_o.
- uart_o  output  1  serial TX line; idle = 1.

Behaviour:
- BitCycles = ClkRate/BaudRate, integer-truncated; 868 at the defaults. Elaboration error if BitCycles < 2.
- Bit-period counter width is $clog2(BitCycles). Bit index width is $clog2(WordSize), minimum 1.

Reset (rst_i high, asynchronous):
- State = IDLE, counters = 0, shift register = 0.
- uart_o = 1 immediately.
- data_ack_o = 0 for as long as rst_i is high.
- Reset mid-frame aborts the frame with no completion; the line returns high at once.

States and transitions:
- IDLE: uart_o = 1.
  - data_ack_o = data_valid_i && !rst_i (combinational).
  - On an edge with data_valid_i = 1: latch data_i into the shift register, clear the counter, go to START.
- START: uart_o = 0 for exactly BitCycles clocks, then go to DATA with bit index 0.
- DATA: uart_o = shift_reg[0]; each bit is held BitCycles clocks.
  - At the end of each bit: shift right, increment the index.
  - After bit WordSize-1, go to STOP.
- STOP: uart_o = 1 for BitCycles clocks, then go to IDLE.

Output timing:
- uart_o is a registered output (decoded from registered state). It falls on the same edge that accepts the word: start bit begins 0 cycles after the handshake edge.
- Frame length is exactly (WordSize+2)*BitCycles clocks.

Handshake rules:
- data_ack_o is never 1 while data_valid_i is 0.
- data_ack_o is 0 in START, DATA and STOP.
- data_ack_o is high for exactly one cycle per accepted word, provided the producer keeps data_valid_i high.
- data_i and data_valid_i changes while busy are ignored. A held-high valid is accepted in the first IDLE cycle after STOP.
- Back-to-back words are supported with one idle cycle minimum between the stop bit and the next start bit. The line stays high in that cycle, so there is no glitch.
- Whenever data_valid_i = 0 and no frame is in progress, uart_o = 1.
- uart_o is never X/Z after reset deassertion.

Test Plan:
- Reset: hold rst_i 100 cycles with data_valid_i = 0 → uart_o = 1, data_ack_o = 0 throughout; release → uart_o stays 1.
- Single word 0xAB:
  - data_ack_o pulses 1 cycle.
  - Line shows start 0, then bits 1,1,0,1,0,1,0,1, then stop 1, each bit 868 clocks (8.68 µs at 100 MHz).
  - Mid-bit sampling decodes 0xAB.
- Back-to-back 0xAB then 0xBC, valid held high for 0xBC:
  - 0xBC is acknowledged only after 0xAB's stop bit completes.
  - Decoder receives 0xAB, 0xBC in order; no ack while busy.
- Idle gap, then 0xCD: after a 10-bit-period gap, send 0xCD → decoded 0xCD. Total received queue = {0xAB, 0xBC, 0xCD}, size 3.
- Protocol assertions every cycle outside reset:
  - never (data_ack_o && !data_valid_i);
  - (!data_valid_i && idle) → uart_o = 1;
  - uart_o is never X.
- Reset asserted mid-DATA of 0x55 → uart_o = 1 immediately, state IDLE. A new 0x3C after release transmits correctly.
